// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into words,
// writes them to consecutive addresses and releases the CPU once a halt word lands.
module imem_loader #(
  parameter int                        NB_INSTRUCTION  = 32,
  parameter int                        NB_BYTE         = 8,
  parameter int                        IMEM_ADDR_WIDTH = 5,
  parameter logic [NB_INSTRUCTION-1:0] HALT_INSTR      = {NB_INSTRUCTION{1'b1}}
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [NB_BYTE-1:0]         i_rx_data,
  input  logic                       i_rx_valid,
  output logic                       o_rx_ready,
  output logic [NB_INSTRUCTION-1:0]  o_imem_data,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr,
  output logic                       o_imem_wen,
  output logic [1:0]                 o_mem_wsize,
  output logic                       o_cpu_en,
  output logic                       o_done,
  output logic                       o_overflow,
  output logic [IMEM_ADDR_WIDTH:0]   o_word_count
);

  // state | meaning
  // IDLE  | waiting for start, stream not accepted
  // LOAD  | accepting bytes into the word register
  // WRITE | one-cycle write strobe of the assembled word
  // DONE  | halt word written, CPU enabled
  // ERR   | memory filled without a halt word
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

  localparam int BPW    = NB_INSTRUCTION / NB_BYTE;
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BIDX_W-1:0]          LAST_BIDX = BIDX_W'(BPW - 1);
  localparam logic [IMEM_ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [IMEM_ADDR_WIDTH:0]   MAX_COUNT = {1'b1, {IMEM_ADDR_WIDTH{1'b0}}};

  state_t                      state_q, state_d;
  logic [NB_INSTRUCTION-1:0]   word_q, word_d;
  logic [IMEM_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BIDX_W-1:0]           bidx_q, bidx_d;
  logic [IMEM_ADDR_WIDTH:0]    count_q, count_d;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      addr_q  <= '0;
      bidx_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      bidx_q  <= bidx_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    bidx_d  = bidx_q;
    count_d = count_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (i_start) begin
          state_d = LOAD;
          word_d  = '0;
          addr_d  = '0;
          bidx_d  = '0;
          count_d = '0;
        end
      end
      LOAD: begin
        if (i_abort) begin
          state_d = IDLE;
          bidx_d  = '0;
        end else if (i_rx_valid) begin
          for (int k = 0; k < BPW; k++) begin
            if (bidx_q == BIDX_W'(k)) word_d[k*NB_BYTE +: NB_BYTE] = i_rx_data;
          end
          if (bidx_q == LAST_BIDX) begin
            state_d = WRITE;
            bidx_d  = '0;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
      WRITE: begin
        // The strobe is already on the bus this cycle, so the write is counted even on abort.
        addr_d = addr_q + 1'b1;
        if (count_q != MAX_COUNT) count_d = count_q + 1'b1;
        if (i_abort)                   state_d = IDLE;
        else if (word_q == HALT_INSTR) state_d = DONE;
        else if (addr_q == LAST_ADDR)  state_d = ERR;
        else                           state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_rx_ready   = (state_q == LOAD);
  assign o_imem_wen   = (state_q == WRITE);
  assign o_imem_data  = word_q;
  assign o_imem_waddr = addr_q;
  assign o_mem_wsize  = 2'b10;
  assign o_cpu_en     = (state_q == DONE);
  assign o_done       = (state_q == DONE);
  assign o_overflow   = (state_q == ERR);
  assign o_word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: drivers push expected writes, a monitor pops
// and compares on every write strobe of the 32-bit and 16-bit instances.
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, abort, valid;
  logic [7:0]  data;
  logic        rdy, wen, cpu_en, done, ovf;
  logic [31:0] wdata;
  logic [4:0]  waddr;
  logic [1:0]  wsize;
  logic [5:0]  count;

  logic        start16, abort16, valid16;
  logic [7:0]  data16;
  logic        rdy16, wen16, cpu_en16, done16, ovf16;
  logic [15:0] wdata16;
  logic [4:0]  waddr16;
  logic [1:0]  wsize16;
  logic [5:0]  count16;

  imem_loader u_dut (
    .clk(clk), .i_rst(rst_n), .i_start(start), .i_abort(abort),
    .i_rx_data(data), .i_rx_valid(valid), .o_rx_ready(rdy),
    .o_imem_data(wdata), .o_imem_waddr(waddr), .o_imem_wen(wen),
    .o_mem_wsize(wsize), .o_cpu_en(cpu_en), .o_done(done),
    .o_overflow(ovf), .o_word_count(count)
  );

  imem_loader #(.NB_INSTRUCTION(16), .HALT_INSTR(16'hFFFF)) u_dut16 (
    .clk(clk), .i_rst(rst_n), .i_start(start16), .i_abort(abort16),
    .i_rx_data(data16), .i_rx_valid(valid16), .o_rx_ready(rdy16),
    .o_imem_data(wdata16), .o_imem_waddr(waddr16), .o_imem_wen(wen16),
    .o_mem_wsize(wsize16), .o_cpu_en(cpu_en16), .o_done(done16),
    .o_overflow(ovf16), .o_word_count(count16)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (wen === 1'b1) begin
      if (q32.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write32: got write %0h @%0d, expected none", wdata, waddr);
      end else begin
        e = q32.pop_front();
        chk("write32_data", 64'(wdata), 64'(e.data));
        chk("write32_addr", 64'(waddr), 64'(e.addr));
      end
    end
    if (wen16 === 1'b1) begin
      if (q16.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write16: got write %0h @%0d, expected none", wdata16, waddr16);
      end else begin
        e = q16.pop_front();
        chk("write16_data", 64'(wdata16), 64'(e.data));
        chk("write16_addr", 64'(waddr16), 64'(e.addr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start16 = 1'b1; else start = 1'b1;
    tick();
    start   = 1'b0;
    start16 = 1'b0;
  endtask

  // Returns at 1 time unit after the edge that accepted the byte.
  task automatic send_byte(input bit sel, input logic [7:0] b, input bit thr);
    bit hs;
    int n;
    if (thr) begin
      repeat ($urandom_range(0, 2)) begin
        if (sel) begin valid16 = 1'b0; data16 = 8'($urandom); end
        else     begin valid   = 1'b0; data   = 8'($urandom); end
        tick();
      end
    end
    if (sel) begin valid16 = 1'b1; data16 = b; end
    else     begin valid   = 1'b1; data   = b; end
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = sel ? rdy16 : rdy;
      @(posedge clk);
      #1;
      n++;
    end
    valid   = 1'b0;
    valid16 = 1'b0;
    if (!hs) begin
      n_tests++;
      n_fail++;
      $display("FAIL byte_accept_timeout: got no handshake in 50 cycles, expected ready");
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic [4:0] a, input bit thr);
    q32.push_back('{data: w, addr: a});
    for (int k = 0; k < 4; k++) send_byte(1'b0, w[8*k +: 8], thr);
    chk("wen_after_last_byte", 64'(wen), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; valid = 1'b0; data = 8'h00;
    start16 = 1'b0; abort16 = 1'b0; valid16 = 1'b0; data16 = 8'h00;
    repeat (2) tick();

    chk("rst_ready",  64'(rdy),    64'd0);
    chk("rst_wen",    64'(wen),    64'd0);
    chk("rst_cpu_en", 64'(cpu_en), 64'd0);
    chk("rst_done",   64'(done),   64'd0);
    chk("rst_ovf",    64'(ovf),    64'd0);
    chk("rst_count",  64'(count),  64'd0);
    chk("rst_wsize",  64'(wsize),  64'd2);
    chk("rst_data",   64'(wdata),  64'd0);
    rst_n = 1'b1;
    tick();

    // reset in the middle of a word
    pulse_start(1'b0);
    chk("start_ready", 64'(rdy), 64'd1);
    send_byte(1'b0, 8'h13, 1'b0);
    send_byte(1'b0, 8'h22, 1'b0);
    valid = 1'b1;
    data  = 8'hAA;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(rdy),   64'd0);
    chk("midrst_data",  64'(wdata), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("postrst_ready", 64'(rdy), 64'd0);
    valid = 1'b0;

    // three-word program, back-to-back bytes
    pulse_start(1'b0);
    send_word(32'h0000_0013, 5'd0, 1'b0);
    send_word(32'h0010_0093, 5'd1, 1'b0);
    send_word(32'hFFFF_FFFF, 5'd2, 1'b0);
    chk("halt_write_cpu_en", 64'(cpu_en), 64'd0);
    tick();
    chk("prog3_done",   64'(done),   64'd1);
    chk("prog3_cpu_en", 64'(cpu_en), 64'd1);
    chk("prog3_count",  64'(count),  64'd3);
    chk("prog3_ovf",    64'(ovf),    64'd0);

    // same program, throttled
    pulse_start(1'b0);
    chk("reload_cpu_en", 64'(cpu_en), 64'd0);
    send_word(32'h0000_0013, 5'd0, 1'b1);
    send_word(32'h0010_0093, 5'd1, 1'b1);
    send_word(32'hFFFF_FFFF, 5'd2, 1'b1);
    tick();
    chk("thr_done",  64'(done),  64'd1);
    chk("thr_count", 64'(count), 64'd3);

    // overflow: 32 non-halt words
    pulse_start(1'b0);
    for (int i = 0; i < 32; i++) send_word(32'h0000_0013, 5'(i), 1'b0);
    tick();
    chk("ovf_flag",   64'(ovf),    64'd1);
    chk("ovf_cpu_en", 64'(cpu_en), 64'd0);
    chk("ovf_done",   64'(done),   64'd0);
    chk("ovf_count",  64'(count),  64'd32);
    chk("ovf_ready",  64'(rdy),    64'd0);

    // halt word in the last slot
    pulse_start(1'b0);
    chk("restart_ovf_clr", 64'(ovf), 64'd0);
    for (int i = 0; i < 31; i++) send_word(32'h0000_0013, 5'(i), 1'b0);
    send_word(32'hFFFF_FFFF, 5'd31, 1'b0);
    tick();
    chk("lastslot_done",  64'(done),  64'd1);
    chk("lastslot_ovf",   64'(ovf),   64'd0);
    chk("lastslot_count", 64'(count), 64'd32);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_done_ignored", 64'(done), 64'd1);

    // abort together with start mid-word, then reload
    pulse_start(1'b0);
    send_byte(1'b0, 8'h93, 1'b0);
    send_byte(1'b0, 8'h00, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_ready", 64'(rdy),   64'd0);
    chk("abort_count", 64'(count), 64'd0);
    repeat (2) tick();
    chk("abort_idle_ready", 64'(rdy), 64'd0);
    pulse_start(1'b0);
    send_word(32'hFFFF_FFFF, 5'd0, 1'b0);
    tick();
    chk("onehalt_done",  64'(done),  64'd1);
    chk("onehalt_count", 64'(count), 64'd1);
    pulse_start(1'b0);
    chk("done_restart_cpu_en", 64'(cpu_en), 64'd0);
    chk("done_restart_ready",  64'(rdy),    64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_load_ready", 64'(rdy), 64'd0);

    // 16-bit instance
    pulse_start(1'b1);
    q16.push_back('{data: 32'h0000_1234, addr: 5'd0});
    q16.push_back('{data: 32'h0000_FFFF, addr: 5'd1});
    send_byte(1'b1, 8'h34, 1'b0);
    send_byte(1'b1, 8'h12, 1'b0);
    chk("w16_wen0", 64'(wen16), 64'd1);
    send_byte(1'b1, 8'hFF, 1'b0);
    send_byte(1'b1, 8'hFF, 1'b0);
    chk("w16_wen1", 64'(wen16), 64'd1);
    tick();
    chk("w16_done",  64'(done16),  64'd1);
    chk("w16_count", 64'(count16), 64'd2);

    repeat (3) tick();
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q16_drained", 64'(q16.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
